// File: rtl/maxi_loader.sv
// rtl/maxi_loader.sv - streaming packer that fills the 2*N-lane input bus of the maxi reduction tree
//
// Accepts one DATA_WIDTH element per in_valid/in_ready handshake and writes it
// into lane idx of out_vec. Once the vector is complete it is held on
// out_vec/out_valid until out_ready is sampled high. It then clears and refills.
// Unused lanes are always zero, which is the unsigned minimum for maxi.
//
// Optional feature: define MAXI_LOADER_PAD_EN to let in_last close a short
// vector early. The remaining lanes stay zero.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst_n      synchronous active-low reset
//   in_data    element to pack
//   in_valid   in_data valid
//   in_ready   loader can accept an element (registered state and rst_n only)
//   in_last    final element of a short vector (MAXI_LOADER_PAD_EN only)
//   out_vec    packed vector, lane k at [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
//   out_valid  out_vec complete and stable
//   out_ready  downstream takes the vector
//   out_count  number of lanes written by input

module maxi_loader #(
    parameter int N          = 256,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DATA_WIDTH-1:0]               in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_last,
    output logic [2*N*DATA_WIDTH-1:0]           out_vec,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(2*N):0]                out_count
);

    localparam int LANES = 2 * N;
    localparam int IW    = $clog2(LANES) + 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                        state, state_next;
    logic [IW-1:0]                 idx, idx_next;
    logic [LANES*DATA_WIDTH-1:0]   vec_next;
    logic [IW-1:0]                 count_next;
    logic                          accept;
    logic                          close_vec;

`ifndef MAXI_LOADER_PAD_EN
    // in_last has no effect unless short vectors are enabled.
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

    // in_ready depends on registered state and rst_n only. This keeps
    // out_ready from reaching in_ready through a combinational path.
    assign in_ready  = rst_n && (state == FILL);
    assign out_valid = (state == FULL);
    assign accept    = in_valid && in_ready;

`ifdef MAXI_LOADER_PAD_EN
    assign close_vec = (idx == IW'(LANES - 1)) || in_last;
`else
    assign close_vec = (idx == IW'(LANES - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            idx       <= '0;
            out_vec   <= '0;
            out_count <= '0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            out_vec   <= vec_next;
            out_count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        vec_next   = out_vec;
        count_next = out_count;
        case (state)
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (idx == IW'(k)) begin
                            vec_next[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
                        end
                    end
                    idx_next = idx + IW'(1);
                    if (close_vec) begin
                        state_next = FULL;
                        count_next = idx + IW'(1);
                    end
                end
            end
            FULL: begin
                // Hold the vector until it is taken. Input is never accepted
                // in the transfer cycle because in_ready is low in FULL.
                if (out_ready) begin
                    state_next = FILL;
                    idx_next   = '0;
                    vec_next   = '0;
                    count_next = '0;
                end
            end
            default: begin
                state_next = FILL;
                idx_next   = '0;
                vec_next   = '0;
                count_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_maxi_loader.sv
// tb/tb_maxi_loader.sv - directed self-checking bench for maxi_loader (N=2, DATA_WIDTH=8)

module tb_maxi_loader;

    localparam int N  = 2;
    localparam int DW = 8;

    logic           clk;
    logic           rst_n;
    logic [DW-1:0]  in_data;
    logic           in_valid;
    logic           in_ready;
    logic           in_last;
    logic [31:0]    out_vec;
    logic           out_valid;
    logic           out_ready;
    logic [2:0]     out_count;

    int checks;
    int errors;

    maxi_loader #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_count", {29'b0, out_count}, 32'd0);
        check("rst_out_vec", out_vec, 32'h0);
        check("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // 1: back-to-back fill with out_ready high
        out_ready = 1'b1;
        push(8'h11);
        check("s1_partial_vec", out_vec, 32'h00000011);
        check("s1_partial_valid", {31'b0, out_valid}, 32'd0);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        in_valid = 1'b0;
        check("s1_out_valid", {31'b0, out_valid}, 32'd1);
        check("s1_out_vec", out_vec, 32'h44332211);
        check("s1_out_count", {29'b0, out_count}, 32'd4);
        check("s1_in_ready_full", {31'b0, in_ready}, 32'd0);
        tick();
        check("s1_in_ready_after", {31'b0, in_ready}, 32'd1);
        check("s1_valid_after", {31'b0, out_valid}, 32'd0);
        check("s1_vec_cleared", out_vec, 32'h0);
        check("s1_count_cleared", {29'b0, out_count}, 32'd0);

        // 2: back-pressure while in_valid stays high with 0xFF
        out_ready = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        in_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s2_hold_in_ready", {31'b0, in_ready}, 32'd0);
            check("s2_hold_valid", {31'b0, out_valid}, 32'd1);
            check("s2_hold_vec", out_vec, 32'h44332211);
            check("s2_hold_count", {29'b0, out_count}, 32'd4);
        end
        out_ready = 1'b1;
        tick();
        check("s2_xfer_vec_cleared", out_vec, 32'h0);
        check("s2_xfer_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b0;
        tick();
        check("s2_lane0_ff", out_vec, 32'h000000FF);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        in_valid = 1'b0;
        check("s2_second_vec", out_vec, 32'h030201FF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 3: in_valid toggling; idle cycles carry garbage data
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = (i % 2 == 0) ? 8'(8'hA1 + i / 2) : 8'hEE;
            tick();
            if (i == 1) begin
                check("s3_gap_no_write", out_vec, 32'h000000A1);
            end
        end
        in_valid = 1'b0;
        check("s3_out_vec", out_vec, 32'hA4A3A2A1);
        check("s3_out_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 4: reset mid-fill discards partial data
        push(8'h05);
        push(8'h06);
        check("s4_partial", out_vec, 32'h00000605);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("s4_rst_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check("s4_rst_valid", {31'b0, out_valid}, 32'd0);
        check("s4_rst_vec", out_vec, 32'h0);
        rst_n = 1'b1;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check("s4_no_early_valid", {31'b0, out_valid}, 32'd0);
        push(8'h04);
        in_valid = 1'b0;
        check("s4_out_vec", out_vec, 32'h04030201);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 5: in_last after two elements
        push(8'h09);
        in_last = 1'b1;
        push(8'h07);
        in_last  = 1'b0;
        in_valid = 1'b0;
`ifdef MAXI_LOADER_PAD_EN
        check("s5_pad_valid", {31'b0, out_valid}, 32'd1);
        check("s5_pad_vec", out_vec, 32'h00000709);
        check("s5_pad_count", {29'b0, out_count}, 32'd2);
        check("s5_pad_in_ready", {31'b0, in_ready}, 32'd0);
`else
        check("s5_nopad_valid", {31'b0, out_valid}, 32'd0);
        check("s5_nopad_in_ready", {31'b0, in_ready}, 32'd1);
        check("s5_nopad_vec", out_vec, 32'h00000709);
        push(8'h0A);
        push(8'h0B);
        in_valid = 1'b0;
        check("s5_nopad_full_valid", {31'b0, out_valid}, 32'd1);
        check("s5_nopad_full_vec", out_vec, 32'h0B0A0709);
        check("s5_nopad_count", {29'b0, out_count}, 32'd4);
`endif
        out_ready = 1'b1;
        tick();
        check("s5_after_xfer_valid", {31'b0, out_valid}, 32'd0);
        check("s5_after_xfer_vec", out_vec, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maxi_loader.md
# maxi_loader

Streaming vector packer that sits in front of the `maxi` reduction tree. It accepts one `DATA_WIDTH` element per handshake and packs `2*N` elements into the flat bus `maxi` consumes. It presents the filled vector with a valid/ready handshake. It is the producer side of the `maxi` input bus; the reduction itself stays combinational downstream.

## Interface
- `N`, 256: number of first-stage comparators downstream; vector holds `LANES = 2*N` elements; power of two, ≥1.
- `DATA_WIDTH`, 32: element width, unsigned.
- `clk`  input  1  single clock, all state on rising edge.
- `rst_n`  input  1  synchronous, active-low reset; sampled on `clk` rising edge.
- `in_data`  input  DATA_WIDTH  element to pack.
- `in_valid`  input  1  `in_data` valid.
- `in_ready`  output  1  loader can accept an element.
- `in_last`  input  1  marks the final element of a short vector; used only with `MAXI_LOADER_PAD_EN`.
- `out_vec`  output  2*N*DATA_WIDTH  packed vector; lane k at bits `[(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]`.
- `out_valid`  output  1  `out_vec` complete and stable.
- `out_ready`  input  1  downstream takes the vector.
- `out_count`  output  $clog2(2*N)+1  number of lanes written by input (rest are padding).

## Operation
- States: FILL, FULL.
- Reset (rst_n low at edge): state FILL, write index 0, `out_vec` all zeros, `out_valid` 0, `out_count` 0. `in_ready` is 0 while `rst_n` is low, otherwise it equals (state == FILL).
- FILL:
  - An element is accepted on `in_valid && in_ready`. It is written to lane `idx`; `idx` increments.
  - When the accepted element is lane `2N-1`, the next state is FULL. `out_count` becomes `2N`.
- FULL:
  - `in_ready` is 0; `out_valid` is 1.
  - `out_vec` and `out_count` are held stable until `out_ready` is sampled high.
  - On `out_valid && out_ready`, the next state is FILL, `idx` is 0, `out_vec` clears to zero, and `out_count` is 0.
- No overlap: input is never accepted in the same cycle as the output transfer.
- `in_data` is ignored when `in_valid` is low or `in_ready` is low. Unused lanes are always zero. Zero is the unsigned minimum, so it never changes the `maxi` result.
- Index arithmetic is unsigned, width `$clog2(2*N)+1`. The index never wraps inside FILL; it resets only on the output transfer or on reset.
- N=1 degenerate case: 2 lanes; FULL is reached after 2 accepts.
- Reset mid-fill or mid-hold discards partial or pending data with no output transfer; the next accepted element goes to lane 0.

## Timing
- Accept of the final lane in cycle T: `out_valid` is high from T+1.
- Output transfer at cycle T (valid && ready): `in_ready` is high from T+1 and `out_valid` is low from T+1.
- Minimum period per vector: 2N+1 cycles (2N accepts, 1 transfer cycle) when `out_ready` is held high.
- `in_ready` depends only on registered state and `rst_n`; there is no combinational path from `out_ready` to `in_ready`.
- `out_valid` deasserts only after a transfer or reset, never spontaneously.

## Configuration
- `MAXI_LOADER_PAD_EN` defined:
  - Accepting an element with `in_last` high in FILL writes that lane and moves to FULL next cycle. Remaining lanes stay zero; `out_count` = `idx+1`.
  - `in_last` on lane `2N-1` behaves the same as a normal fill.
- `MAXI_LOADER_PAD_EN` undefined:
  - `in_last` is ignored; only a full `2N`-element fill produces an output.
  - `out_count` is always `2N` when `out_valid` is high.

## Test plan
All scenarios use N=2, DATA_WIDTH=8 (4 lanes).
- Reset then 4 back-to-back accepts 0x11,0x22,0x33,0x44 with `out_ready` high. Required: `out_vec`=0x44332211 and `out_count`=4 in the cycle after the 4th accept; transfer completes that cycle; `in_ready` is high on the next cycle.
- Full vector with `out_ready` held low for 5 cycles, `in_valid` held high with 0xFF. Required: `in_ready`=0, `out_vec` stable at 0x44332211, no element accepted; release `out_ready`, and next vector's lane 0 = 0xFF.
- `in_valid` toggling 1,0,1,0… over 8 cycles with 0xA1..0xA4. Required: `out_vec`=0xA4A3A2A1; the 0-valid cycles write nothing.
- `rst_n` low for 1 cycle after 2 accepts (0x05,0x06), then 4 accepts 0x01..0x04. Required: `out_vec`=0x04030201; `out_valid` was 0 throughout reset.
- With `MAXI_LOADER_PAD_EN`: accepts 0x09 then 0x07 with `in_last`. Required: `out_vec`=0x00000709, `out_count`=2. Without the macro, the same stimulus produces no `out_valid` until 2 more accepts.
